// File: rtl/led_fade_pkg.sv
// rtl/led_fade_pkg.sv - channel state encoding and brightness constants for the LED fade driver
package led_fade_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ON     = 2'd1,
    FADING = 2'd2
  } ch_state_t;

  // Full-scale brightness for a given PWM width (also the last PWM count of a frame).
  function automatic int bright_max(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_if.sv
// rtl/led_fade_if.sv - pattern source / LED driver signal bundle
interface led_fade_if #(
  parameter int NUM_LEDS = 8
) (
  input logic clk
);
  logic                reset_n;
  logic [NUM_LEDS-1:0] pattern_in;
  logic [NUM_LEDS-1:0] led_out;
  logic                frame_tick;

  modport master (
    input  clk,
    output reset_n,
    output pattern_in,
    input  led_out,
    input  frame_tick
  );

  modport slave (
    input  clk,
    input  reset_n,
    input  pattern_in,
    output led_out,
    output frame_tick
  );
endinterface

// File: rtl/led_fade_channel.sv
// rtl/led_fade_channel.sv - one LED channel: on/fade state, brightness, PWM compare
// Macro LED_FADE_GAMMA_EN squares the brightness before the compare.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                set,
  input  logic                decay_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);
  localparam logic [PWM_BITS-1:0] B_MAX = PWM_BITS'(bright_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP  = PWM_BITS'(DECAY_STEP);

  ch_state_t           state;
  ch_state_t           state_nxt;
  logic [PWM_BITS-1:0] b;
  logic [PWM_BITS-1:0] b_nxt;
  logic [PWM_BITS-1:0] cmp;
  logic                led_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= OFF;
      b     <= '0;
      led   <= 1'b0;
    end else begin
      state <= state_nxt;
      b     <= b_nxt;
      led   <= led_nxt;
    end
  end

  // A set bit wins over a coincident decay tick.
  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    if (set) begin
      state_nxt = ON;
      b_nxt     = B_MAX;
    end else begin
      case (state)
        ON: state_nxt = FADING;
        FADING: begin
          if (decay_tick) begin
            if (b > STEP) begin
              b_nxt = b - STEP;
            end else begin
              b_nxt     = '0;
              state_nxt = OFF;
            end
          end
        end
        default: begin
          state_nxt = OFF;
          b_nxt     = '0;
        end
      endcase
    end
  end

`ifdef LED_FADE_GAMMA_EN
  assign cmp = PWM_BITS'(({{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b}) >> PWM_BITS);
`else
  assign cmp = b;
`endif

  always_comb begin
    led_nxt = (b == B_MAX) || (pwm_cnt < cmp);
  end

endmodule

// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - PWM/frame timebase and per-LED fade channels
// Optional macro LED_FADE_GAMMA_EN (see led_fade_channel).
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 4,
  parameter int DECAY_STEP = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                frame_tick
);
  localparam int                  FRM_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(bright_max(PWM_BITS));
  localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FRM_W-1:0]    frame_cnt;
  logic                frame_end;
  logic                decay_tick;

  assign frame_end  = (pwm_cnt == PWM_LAST);
  assign decay_tick = frame_end && (frame_cnt == FRM_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt    <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_tick <= frame_end;
      if (frame_end) begin
        frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .set       (pattern_in[i]),
      .decay_tick(decay_tick),
      .pwm_cnt   (pwm_cnt),
      .led       (led_out[i])
    );
  end

endmodule
